// File: rtl/spi_rom_line_fetch_if.sv
// Request/response bundle between the scanline logic (master) and the SPI ROM
// line fetch engine (slave).
interface spi_rom_line_fetch_if #(
    parameter int DATA_BITS = 16
) ();
    logic                 start;
    logic [23:0]          addr;
    logic                 busy;
    logic                 done;
    logic [DATA_BITS-1:0] data;

    modport master (
        output start,
        output addr,
        input  busy,
        input  done,
        input  data
    );

    modport slave (
        input  start,
        input  addr,
        output busy,
        output done,
        output data
    );
endinterface

// File: rtl/spi_rom_line_fetch.sv
// SPI flash READ engine: sends CMD plus a 24-bit address, shifts in DATA_BITS bits
// MSB-first and presents them as one word with a single-cycle done pulse.
module spi_rom_line_fetch #(
    parameter int         DATA_BITS = 16,
    parameter logic [7:0] CMD       = 8'h03
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_rom_line_fetch_if.slave bus,
    output logic             spi_cs_n,
    output logic             spi_sclk,
    output logic             spi_mosi,
    input  logic             spi_miso
);

    localparam int DCW = $clog2(DATA_BITS) + 1;
    localparam logic [DCW-1:0] D_LAST = DCW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_ADDR = 3'd2,
        S_DATA = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t               state_q;
    logic                 phase_q;
    logic [4:0]           bit_cnt_q;
    logic [DCW-1:0]       dcnt_q;
    logic [31:0]          out_sr_q;
    logic [DATA_BITS-1:0] in_sr_q;
    logic [DATA_BITS-1:0] in_sr_d;
    logic [DATA_BITS-1:0] data_q;
    logic                 cs_n_q;
    logic                 sclk_q;
    logic                 mosi_q;
    logic                 busy_q;
    logic                 done_q;

    // Incoming word with the current miso bit appended at the LSB end.
    assign in_sr_d = DATA_BITS'({in_sr_q, spi_miso});

    // Transaction sequencer; phase_q=0 is the low half of a bit, 1 the high half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            phase_q   <= 1'b0;
            bit_cnt_q <= 5'd0;
            dcnt_q    <= '0;
            out_sr_q  <= 32'd0;
            in_sr_q   <= '0;
            data_q    <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cs_n_q <= 1'b1;
                    sclk_q <= 1'b0;
                    mosi_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (bus.start) begin
                        state_q   <= S_CMD;
                        phase_q   <= 1'b0;
                        bit_cnt_q <= 5'd0;
                        cs_n_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        mosi_q    <= CMD[7];
                        // Remaining command bits and the address queue up behind the first bit.
                        out_sr_q  <= {CMD[6:0], bus.addr, 1'b0};
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_CMD, S_ADDR: begin
                    if (!phase_q) begin
                        phase_q <= 1'b1;
                        sclk_q  <= 1'b1;
                    end else begin
                        phase_q <= 1'b0;
                        sclk_q  <= 1'b0;
                        if ((state_q == S_ADDR) && (bit_cnt_q == 5'd23)) begin
                            state_q <= S_DATA;
                            mosi_q  <= 1'b0;
                            dcnt_q  <= '0;
                        end else begin
                            mosi_q   <= out_sr_q[31];
                            out_sr_q <= {out_sr_q[30:0], 1'b0};
                            if ((state_q == S_CMD) && (bit_cnt_q == 5'd7)) begin
                                state_q   <= S_ADDR;
                                bit_cnt_q <= 5'd0;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (!phase_q) begin
                        phase_q <= 1'b1;
                        sclk_q  <= 1'b1;
                    end else begin
                        phase_q <= 1'b0;
                        sclk_q  <= 1'b0;
                        in_sr_q <= in_sr_d;
                        // The word is published only once complete, together with done.
                        if (dcnt_q == D_LAST) begin
                            state_q <= S_DONE;
                            cs_n_q  <= 1'b1;
                            data_q  <= in_sr_d;
                            done_q  <= 1'b1;
                        end else begin
                            dcnt_q <= dcnt_q + DCW'(1'b1);
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    cs_n_q  <= 1'b1;
                    sclk_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    phase_q <= 1'b0;
                    cs_n_q  <= 1'b1;
                    sclk_q  <= 1'b0;
                    mosi_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign spi_cs_n = cs_n_q;
    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.data = data_q;

endmodule

// File: tb/tb_spi_rom_line_fetch.sv
// Scoreboard bench for spi_rom_line_fetch: a behavioural SPI ROM answers the
// engine, stimulus pushes expected words/done cycles, monitors pop and compare.
module tb_spi_rom_line_fetch;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_rom_line_fetch_if #(.DATA_BITS(16)) bus ();
    spi_rom_line_fetch_if #(.DATA_BITS(1))  bus1 ();

    logic cs_n, sclk, mosi, miso;
    logic cs1_n, sclk1, mosi1;
    logic miso1 = 1'b1;

    spi_rom_line_fetch #(.DATA_BITS(16), .CMD(8'h03)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .spi_cs_n(cs_n), .spi_sclk(sclk), .spi_mosi(mosi), .spi_miso(miso)
    );

    spi_rom_line_fetch #(.DATA_BITS(1), .CMD(8'h03)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .spi_cs_n(cs1_n), .spi_sclk(sclk1), .spi_mosi(mosi1), .spi_miso(miso1)
    );

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;

    // Edge number of the most recent rising clk edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    typedef struct {
        logic [15:0] data;
        int unsigned done_edge;
    } exp_t;

    exp_t        sbq[$];
    int unsigned sbq1[$];
    exp_t        e;
    int unsigned e1;

    // ROM contents: one hand-picked word, otherwise the low address bits XOR 5A5A.
    function automatic logic [15:0] rom_word(input logic [23:0] a);
        if (a == 24'h0A1B2C) return 16'hBEEF;
        else return a[15:0] ^ 16'h5A5A;
    endfunction

    logic [23:0] exp_addr = 24'd0;
    bit          b2b = 1'b0;
    bit          had_txn = 1'b0;
    int          nbits = 0;
    int          lowcnt = 0;
    int          highcnt = 0;
    logic [31:0] rx = 32'd0;
    logic [15:0] word = 16'd0;

    // Behavioural SPI ROM, also checking the command stream and chip-select timing.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nbits   <= 0;
            lowcnt  <= 0;
            highcnt <= 0;
            miso    <= 1'b0;
        end else if (cs_n) begin
            if (lowcnt != 0) begin
                chk("cs_low_len", lowcnt, 32'd96);
                had_txn <= 1'b1;
            end
            chk("sclk_idle_low", {31'd0, sclk}, 32'd0);
            lowcnt  <= 0;
            nbits   <= 0;
            highcnt <= highcnt + 1;
        end else begin
            if (lowcnt == 0 && b2b && had_txn) chk("cs_gap", highcnt, 32'd2);
            highcnt <= 0;
            lowcnt  <= lowcnt + 1;
            if (sclk) begin
                rx    <= {rx[30:0], mosi};
                nbits <= nbits + 1;
                if (nbits == 31) begin
                    chk("cmd_addr", {rx[30:0], mosi}, {8'h03, exp_addr});
                    word <= rom_word({rx[22:0], mosi});
                end
            end else if (nbits >= 32) begin
                miso <= word[47 - nbits];
            end
        end
    end

    logic prev_done = 1'b0;

    // Scoreboard monitor for the 16-bit engine.
    always @(negedge clk) begin
        prev_done <= bus.done && rst_n;
        if (prev_done) begin
            chk("done_width", {31'd0, bus.done}, 32'd0);
            chk("busy_after_done", {31'd0, bus.busy}, 32'd0);
        end
        if (rst_n && bus.done) begin
            chk("cs_at_done", {31'd0, cs_n}, 32'd1);
            chk("busy_at_done", {31'd0, bus.busy}, 32'd1);
            if (sbq.size() == 0) begin
                chk("unexpected_done", sbq.size(), 32'd1);
            end else begin
                e = sbq.pop_front();
                chk("data", {16'd0, bus.data}, {16'd0, e.data});
                chk("done_edge", cyc + 1, e.done_edge);
            end
        end
    end

    int low1 = 0;

    // Scoreboard monitor for the 1-bit engine.
    always @(negedge clk) begin
        if (!cs1_n) begin
            low1 <= low1 + 1;
        end else if (low1 != 0) begin
            chk("cs1_low_len", low1, 32'd66);
            low1 <= 0;
        end
        if (rst_n && bus1.done) begin
            if (sbq1.size() == 0) begin
                chk("unexpected_done1", sbq1.size(), 32'd1);
            end else begin
                e1 = sbq1.pop_front();
                chk("data1", {31'd0, bus1.data}, 32'd1);
                chk("done_edge1", cyc + 1, e1);
            end
        end
    end

    // Called on a falling edge while idle; the next rising edge (E0) accepts.
    task automatic start_txn(input logic [23:0] a, input logic [15:0] d, input bit push,
                             output int unsigned e0);
        bus.addr  = a;
        bus.start = 1'b1;
        e0        = cyc + 1;
        exp_addr  = a;
        if (push) sbq.push_back('{d, e0 + 97});
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_edge(input int unsigned target);
        int n = 0;
        while (cyc < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_edge_timeout", {31'd0, n < 2000}, 32'd1);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((sbq.size() != 0 || sbq1.size() != 0 || bus.busy || bus1.busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", {31'd0, n < budget}, 32'd1);
        @(negedge clk);
    endtask

    int unsigned e0;

    initial begin
        bus.start  = 1'b0;
        bus.addr   = 24'd0;
        bus1.start = 1'b0;
        bus1.addr  = 24'd0;
        rst_n      = 1'b1;
        #1 rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
        chk("rst_sclk", {31'd0, sclk}, 32'd0);
        chk("rst_mosi", {31'd0, mosi}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_data", {16'd0, bus.data}, 32'd0);

        // Single fetch of the BEEF word.
        start_txn(24'h0A1B2C, 16'hBEEF, 1'b1, e0);
        chk("busy_after_accept", {31'd0, bus.busy}, 32'd1);
        chk("cs_after_accept", {31'd0, cs_n}, 32'd0);
        wait_drain(300);

        // start held high: three back-to-back fetches, 98 edges apart.
        bus.addr  = 24'h001234;
        exp_addr  = 24'h001234;
        bus.start = 1'b1;
        e0 = cyc + 1;
        for (int k = 0; k < 3; k++) sbq.push_back('{16'h486E, e0 + 97 + 98 * k});
        @(negedge clk);
        @(negedge clk);
        b2b = 1'b1;
        wait_edge(e0 + 196);
        bus.start = 1'b0;
        wait_drain(400);
        b2b = 1'b0;

        // Mid-transaction start with a different address is ignored.
        start_txn(24'h00ABCD, 16'hF197, 1'b1, e0);
        wait_edge(e0 + 39);
        bus.addr  = 24'h000F0F;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_drain(300);
        chk("data_held", {16'd0, bus.data}, 32'h0000F197);

        // Asynchronous reset in flight aborts without a done pulse.
        start_txn(24'h000011, 16'h0000, 1'b0, e0);
        wait_edge(e0 + 49);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_cs_n", {31'd0, cs_n}, 32'd1);
        chk("abort_sclk", {31'd0, sclk}, 32'd0);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        chk("abort_data", {16'd0, bus.data}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_data", {16'd0, bus.data}, 32'd0);
        start_txn(24'h000022, 16'h5A78, 1'b1, e0);
        wait_drain(300);

        // One-bit engine with miso tied high.
        bus1.addr  = 24'h000100;
        bus1.start = 1'b1;
        e0 = cyc + 1;
        sbq1.push_back(e0 + 67);
        @(negedge clk);
        bus1.start = 1'b0;
        wait_drain(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
